// File: rtl/apb_slave_regbank_pkg.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank_pkg
// Shared definitions for the APB register-bank slave: register offsets,
// access-FSM state encoding, the default ID constant and the error decode
// applied when a setup phase is accepted.
// ---------------------------------------------------------------------------
package apb_slave_regbank_pkg;

    // Word offsets of the two read-only registers; 0..5 are read/write.
    localparam logic [2:0]  REG_CNT          = 3'd6;
    localparam logic [2:0]  REG_ID           = 3'd7;
    localparam int          NUM_RW_REGS      = 6;
    localparam logic [31:0] DEFAULT_ID_VALUE = 32'hA5B0_0001;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apbState_e;

    // A transfer is rejected when the byte address is not word aligned or
    // when it tries to write one of the read-only registers.
    function automatic logic isBadAccess(input logic write, input logic [31:0] addr);
        return (addr[1:0] != 2'b00) ||
               (write && ((addr[4:2] == REG_CNT) || (addr[4:2] == REG_ID)));
    endfunction

endpackage

// File: rtl/apb_slave_regbank_wait.sv
// ---------------------------------------------------------------------------
// apb_wait_ctrl
// Wait-state counter and registered ready generation for an APB completer.
// The counter is loaded when a setup phase is accepted and counts down while
// the access phase is held; ready rises on the edge where it reaches zero
// (or straight from setup when no wait states are configured).
//
// Ports:
//   clk_i       clock
//   rst_ni      asynchronous active-low reset
//   start_i     setup phase accepted this cycle
//   hold_i      access phase in progress with the slave still selected
//   clear_i     transfer completed or aborted; drop ready and the counter
//   ready_o     registered ready
//   readySet_o  ready will rise on the coming edge (lets the parent register
//               its response data in the same edge)
// ---------------------------------------------------------------------------
module apb_wait_ctrl #(
    parameter int WAIT_STATES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic start_i,
    input  logic hold_i,
    input  logic clear_i,
    output logic ready_o,
    output logic readySet_o
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);

    logic [3:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;

    // Clear has priority; start and hold cannot overlap because start only
    // happens from IDLE and hold only during ACCESS.
    always_comb begin
        cnt_d      = cnt_q;
        ready_d    = ready_q;
        readySet_o = 1'b0;
        if (clear_i) begin
            cnt_d   = 4'd0;
            ready_d = 1'b0;
        end else if (start_i) begin
            cnt_d = WAIT_LOAD;
            if (WAIT_LOAD == 4'd0) begin
                ready_d    = 1'b1;
                readySet_o = 1'b1;
            end
        end else if (hold_i && !ready_q) begin
            if (cnt_q <= 4'd1) begin
                cnt_d      = 4'd0;
                ready_d    = 1'b1;
                readySet_o = 1'b1;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q   <= 4'd0;
            ready_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/apb_slave_regbank.sv
// ---------------------------------------------------------------------------
// apb_slave_regbank
// APB completer with six read/write registers, a read-only count of
// completed non-error transfers (offset 6) and a read-only ID (offset 7).
// Inserts WAIT_STATES wait cycles per transfer; all outputs are registered.
//
// Ports:
//   Hclk     clock shared with the bridge
//   Hresetn  asynchronous active-low reset
//   Psel     one-hot slave select, only Psel[SEL_IDX] is used
//   Penable  access-phase strobe
//   Pwrite   1 = write, 0 = read
//   Paddr    byte address, Paddr[4:2] selects the register
//   Pwdata   write data
//   Pr_data  read data, non-zero only in the ready cycle of a good read
//   Pready   transfer completion
//   Pslverr  error response, valid with Pready
// ---------------------------------------------------------------------------
module apb_slave_regbank
    import apb_slave_regbank_pkg::*;
#(
    parameter int          SEL_IDX     = 0,
    parameter int          WAIT_STATES = 2,
    parameter logic [31:0] ID_VALUE    = DEFAULT_ID_VALUE
) (
    input  logic        Hclk,
    input  logic        Hresetn,
    input  logic [2:0]  Psel,
    input  logic        Penable,
    input  logic        Pwrite,
    input  logic [31:0] Paddr,
    input  logic [31:0] Pwdata,
    output logic [31:0] Pr_data,
    output logic        Pready,
    output logic        Pslverr
);

    apbState_e   state_q, state_d;
    logic        write_q, write_d;
    logic [2:0]  offset_q, offset_d;
    logic [31:0] wdata_q, wdata_d;
    logic        err_q, err_d;
    logic [31:0] prData_q, prData_d;
    logic        slverr_q, slverr_d;
    logic [31:0] regs_q [NUM_RW_REGS];
    logic [31:0] regs_d [NUM_RW_REGS];
    logic [31:0] xferCnt_q, xferCnt_d;

    logic        sel;
    logic        setup;
    logic        abort;
    logic        complete;
    logic        hold;
    logic        ready;
    logic        readySet;
    logic        curWrite;
    logic [2:0]  curOffset;
    logic        curErr;
    logic [31:0] readVal;
    logic        unusedBits;

    // Only the register offset bits and our own select bit are decoded.
    assign unusedBits = ^{Paddr[31:5], Psel};

    assign sel      = Psel[SEL_IDX];
    assign setup    = (state_q == IDLE) && sel && !Penable;
    assign hold     = (state_q == ACCESS) && sel;
    assign abort    = (state_q == ACCESS) && !sel;
    assign complete = hold && Penable && ready;

    apb_wait_ctrl #(
        .WAIT_STATES (WAIT_STATES)
    ) u_wait (
        .clk_i      (Hclk),
        .rst_ni     (Hresetn),
        .start_i    (setup),
        .hold_i     (hold),
        .clear_i    (complete || abort),
        .ready_o    (ready),
        .readySet_o (readySet)
    );

    // With zero wait states the response is registered on the setup edge,
    // so the transfer attributes come straight from the bus in that case.
    assign curWrite  = setup ? Pwrite                   : write_q;
    assign curOffset = setup ? Paddr[4:2]               : offset_q;
    assign curErr    = setup ? isBadAccess(Pwrite, Paddr) : err_q;

    // Read mux; the counter is sampled before this transfer's increment
    // because the increment happens on the later completion edge.
    always_comb begin
        readVal = 32'h0;
        if (curOffset == REG_ID) begin
            readVal = ID_VALUE;
        end else if (curOffset == REG_CNT) begin
            readVal = xferCnt_q;
        end else begin
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                if (curOffset == 3'(i)) begin
                    readVal = regs_q[i];
                end
            end
        end
    end

    // Access FSM, transfer capture, response and register commit.
    always_comb begin
        state_d   = state_q;
        write_d   = write_q;
        offset_d  = offset_q;
        wdata_d   = wdata_q;
        err_d     = err_q;
        prData_d  = prData_q;
        slverr_d  = slverr_q;
        regs_d    = regs_q;
        xferCnt_d = xferCnt_q;

        case (state_q)
            IDLE: begin
                if (setup) begin
                    state_d  = ACCESS;
                    write_d  = Pwrite;
                    offset_d = Paddr[4:2];
                    wdata_d  = Pwdata;
                    err_d    = isBadAccess(Pwrite, Paddr);
                end
            end
            ACCESS: begin
                if (abort || complete) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (complete || abort) begin
            prData_d = 32'h0;
            slverr_d = 1'b0;
        end else if (readySet) begin
            prData_d = (!curWrite && !curErr) ? readVal : 32'h0;
            slverr_d = curErr;
        end

        if (complete && !err_q) begin
            xferCnt_d = xferCnt_q + 32'd1;
            if (write_q) begin
                for (int i = 0; i < NUM_RW_REGS; i++) begin
                    if (offset_q == 3'(i)) begin
                        regs_d[i] = wdata_q;
                    end
                end
            end
        end
    end

    always_ff @(posedge Hclk or negedge Hresetn) begin
        if (!Hresetn) begin
            state_q   <= IDLE;
            write_q   <= 1'b0;
            offset_q  <= 3'd0;
            wdata_q   <= 32'h0;
            err_q     <= 1'b0;
            prData_q  <= 32'h0;
            slverr_q  <= 1'b0;
            xferCnt_q <= 32'h0;
            for (int i = 0; i < NUM_RW_REGS; i++) begin
                regs_q[i] <= 32'h0;
            end
        end else begin
            state_q   <= state_d;
            write_q   <= write_d;
            offset_q  <= offset_d;
            wdata_q   <= wdata_d;
            err_q     <= err_d;
            prData_q  <= prData_d;
            slverr_q  <= slverr_d;
            xferCnt_q <= xferCnt_d;
            regs_q    <= regs_d;
        end
    end

    assign Pr_data = prData_q;
    assign Pready  = ready;
    assign Pslverr = slverr_q;

endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
- APB responder at the far end of the AHB-to-APB bridge. It is the completer that the bridge's Psel/Penable/Paddr/Pwdata/Pwrite drive.
- Contains a small memory-mapped register file and inserts a programmable number of wait states through Pready.
- Returns read data on Pr_data and flags bad accesses on Pslverr.
- Used as the real peripheral model in the top-level bench, replacing the pass-through APB interface.

Parameters:
- SEL_IDX, 0: which bit of the 3-bit Psel bus selects this slave.
- WAIT_STATES, 2: number of access-phase cycles with Pready low before completion. Legal range 0..15.
- ID_VALUE, 32'hA5B0_0001: constant read back from register 7.

Ports:
- Hclk  input  1  APB clock, shared with the bridge.
- Hresetn  input  1  asynchronous active-low reset.
- Psel  input  3  one-hot slave select; only Psel[SEL_IDX] is used.
- Penable  input  1  APB access-phase strobe.
- Pwrite  input  1  1 = write, 0 = read.
- Paddr  input  32  byte address; Paddr[4:2] is the register offset.
- Pwdata  input  32  write data.
- Pr_data  output  32  read data, registered.
- Pready  output  1  transfer completion, registered.
- Pslverr  output  1  error response, registered.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (Hclk, Hresetn).
  - Asserting Hresetn low clears Pr_data=0, Pready=0, Pslverr=0, FSM=IDLE, wait counter=0.
  - Registers 0..5 clear to 0; transfer counter (reg 6) clears to 0.
  - Reset mid-transfer aborts the transfer with no register update.
- Register map (word offsets):
  - 0..5: read/write, 32-bit.
  - 6: read-only count of completed non-error transfers. 32-bit, wraps FFFF_FFFF -> 0.
  - 7: read-only ID_VALUE.
- FSM states:
  - IDLE: on an edge with Psel[SEL_IDX]=1 and Penable=0 (setup phase seen), latch Pwrite/Paddr/Pwdata, load cnt=WAIT_STATES, go to ACCESS.
  - ACCESS: Penable=1 expected.
    - While cnt>0: Pready=0 and cnt decrements each cycle.
    - Pready is high in exactly the (WAIT_STATES+1)-th access cycle. It is registered, so it is set on the edge when cnt reaches 0, or directly from setup when WAIT_STATES=0.
    - On the edge where Psel&Penable&Pready are all sampled high, the transfer completes: commit the write, bump the counter, go to IDLE, drop Pready.
  - Back-to-back transfers: a new setup phase in the cycle after completion is accepted normally. There is no forced idle cycle.
- Error rules, evaluated at setup, with the response presented with Pready:
  - Paddr[1:0] != 0 gives Pslverr=1.
  - A write to offset 6 or 7 gives Pslverr=1.
  - An error write does not update any register. An error transfer does not increment reg 6.
  - An error read returns Pr_data=0.
- Pr_data carries the read value only in the Pready cycle of a read. It is 0 at all other times, including for writes.
- Pslverr is high only in the Pready cycle.
- Protocol violations:
  - Psel[SEL_IDX] drops during ACCESS: abort, return to IDLE, no write, no count.
  - Penable=1 in IDLE without a prior setup: ignored.
  - Psel of another slave: ignored.
- Reading reg 6 returns the value before this transfer's increment. A read of reg 6 itself counts.
- Address bits above [4:2] are ignored. Decode is by Psel only.

Decomposition:
- Shared package: register offset constants (REG_ID=7, REG_CNT=6), FSM state encoding (IDLE, ACCESS), default ID_VALUE.
- One natural sub-module, apb_wait_ctrl: the wait counter plus Pready generation, reusable by later APB slaves.
- The register file and error decode stay in the top.

Test Plan:
- Reset, then write 32'hDEAD_BEEF to Paddr 32'h0000_0004 with WAIT_STATES=2: Pready low for 2 access cycles, high in the 3rd; Pslverr=0. A read of offset 1 returns DEAD_BEEF; reg 6 then reads 2.
- Read offset 7: Pr_data=32'hA5B0_0001 in the Pready cycle and 0 before it. A write of 32'h1234 to offset 7 gives Pslverr=1, and the next read still returns A5B0_0001.
- Misaligned read at Paddr 32'h0000_0002: Pslverr=1, Pr_data=0, and reg 6 is unchanged.
- Rebuild with WAIT_STATES=0: Pready is high in the first access cycle. Back-to-back write then read to offset 3 with no idle cycle returns the written value.
- Drop Psel in the first access cycle of a write of 32'h5555_5555 to offset 0: no Pready; offset 0 still reads its old value; reg 6 is unchanged.
- Assert Hresetn=0 mid-access with WAIT_STATES=4: Pready, Pslverr and Pr_data go to 0 immediately (asynchronously); after release, all registers 0..6 read 0.
